pc_sequencer: RTL and testbench

Owns the fetch PC register and sequences every PC update in the pipelined core. It resolves EX-stage branch/jump outcomes and drives the instruction-fetch request handshake. It also issues the flush pulses that squash wrong-path instructions in IF/ID and ID/EX. It replaces the free-running PC plus combinational next-address select with a controller that stays correct under fetch back-pressure and decode stalls.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/branch_cond.sv | 41 ++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants for the fetch PC sequencer: PCSrc codes, reset/trap vectors, FSM states.
// Used by both pc_sequencer and branch_cond; trap behaviour is selected by MISALIGN_TRAP_EN.
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam logic [2:0] PCSRC_SEQ  = 3'b000;
  localparam logic [2:0] PCSRC_BLT  = 3'b001;
  localparam logic [2:0] PCSRC_BGE  = 3'b010;
  localparam logic [2:0] PCSRC_BEQ  = 3'b011;
  localparam logic [2:0] PCSRC_BNE  = 3'b100;
  localparam logic [2:0] PCSRC_JAL  = 3'b101;
  localparam logic [2:0] PCSRC_JALR = 3'b110;
  localparam logic [2:0] PCSRC_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Resolves an EX-stage control-flow instruction into taken / target / misaligned.
// With MISALIGN_TRAP_EN a target with bit 1 set becomes TRAP_VEC; otherwise it is word-aligned.
module branch_cond
  import pc_seq_pkg::*;
(
  input  logic [2:0]  br_src,
  input  logic        br_zero,
  input  logic        br_less,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  output logic        taken,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] raw_target;

  always_comb begin
    taken = 1'b0;
    case (br_src)
      PCSRC_BLT:            taken = br_less;
      PCSRC_BGE:            taken = !br_less;
      PCSRC_BEQ:            taken = br_zero;
      PCSRC_BNE:            taken = !br_zero;
      PCSRC_JAL, PCSRC_JALR: taken = 1'b1;
      default:              taken = 1'b0;
    endcase

    // jalr clears bit 0 of the computed address
    raw_target = (br_src == PCSRC_JALR) ? (jalr_target & ~32'h1) : br_target;

`ifdef MISALIGN_TRAP_EN
    misaligned = raw_target[1];
    target     = misaligned ? TRAP_VEC : raw_target;
`else
    misaligned = 1'b0;
    target     = raw_target & ~32'h3;
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences PC updates, drives the fetch handshake and issues flush pulses.
// Optional misaligned-jump trap is enabled by defining MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [2:0]  br_src,
  input  logic        br_zero,
  input  logic        br_less,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ready,
  output logic        fetch_kill,
  output logic        redirect,
  output logic        misalign_trap,
  output logic [31:0] pc
);

  state_t      state;
  logic [31:0] pend;
  logic        blank;
  logic        taken;
  logic        misaligned;
  logic [31:0] target;
  logic        taken_ev;

  branch_cond u_cond (
    .br_src      (br_src),
    .br_zero     (br_zero),
    .br_less     (br_less),
    .br_target   (br_target),
    .jalr_target (jalr_target),
    .taken       (taken),
    .target      (target),
    .misaligned  (misaligned)
  );

  // EX holds a flushed bubble the cycle after a redirect, so its br_valid is ignored
  assign taken_ev      = !rst && br_valid && taken && !blank;
  assign redirect      = taken_ev;
  assign misalign_trap = taken_ev && misaligned;
  assign if_addr       = pc;

  always_comb begin
    if_req     = 1'b0;
    fetch_kill = 1'b0;
    case (state)
      ST_RUN:   if_req = !taken_ev && !stall;
      ST_HOLD: begin
        if_req     = 1'b1;
        fetch_kill = taken_ev && if_ready;
      end
      ST_DRAIN: begin
        if_req     = 1'b1;
        fetch_kill = if_ready;
      end
      default:  if_req = 1'b0;
    endcase
    if (rst) begin
      if_req     = 1'b0;
      fetch_kill = 1'b0;
    end
  end

  // An outstanding request is never retracted; a redirect seen meanwhile is parked in pend
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      pend  <= 32'h0;
      blank <= 1'b0;
    end else begin
      blank <= taken_ev;
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          if (taken_ev) pc <= target;
        end
        ST_RUN: begin
          if (taken_ev)                pc <= target;
          else if (if_req && if_ready) pc <= pc + PC_STEP;
          else if (if_req)             state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (taken_ev && if_ready) begin
            pc    <= target;
            state <= ST_RUN;
          end else if (taken_ev) begin
            pend  <= target;
            state <= ST_DRAIN;
          end else if (if_ready) begin
            pc    <= pc + PC_STEP;
            state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (if_ready) begin
            pc    <= taken_ev ? target : pend;
            state <= ST_RUN;
          end else if (taken_ev) begin
            pend <= target;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; trap expectations follow MISALIGN_TRAP_EN.
module tb_pc_sequencer;

  localparam logic [2:0] SEQ = 3'b000, BLT = 3'b001, BGE = 3'b010, BEQ = 3'b011;
  localparam logic [2:0] BNE = 3'b100, JAL = 3'b101, JALR = 3'b110, RSV = 3'b111;

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        v;
    logic [2:0]  src;
    logic        z;
    logic        l;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        st;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eredir;
    logic        ekill;
    logic        etrap;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_src;
  logic        br_zero;
  logic        br_less;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        fetch_kill;
  logic        redirect;
  logic        misalign_trap;
  logic [31:0] pc;

  int compared = 0;
  int failed   = 0;
  vec_t vecs[$];

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .br_valid      (br_valid),
    .br_src        (br_src),
    .br_zero       (br_zero),
    .br_less       (br_less),
    .br_target     (br_target),
    .jalr_target   (jalr_target),
    .stall         (stall),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_ready      (if_ready),
    .fetch_kill    (fetch_kill),
    .redirect      (redirect),
    .misalign_trap (misalign_trap),
    .pc            (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic v, input logic [2:0] src, input logic z,
                        input logic l, input logic [31:0] bt, input logic [31:0] jt,
                        input logic st, input logic rdy, input logic ereq,
                        input logic [31:0] eaddr, input logic eredir, input logic ekill,
                        input logic etrap);
    vec_t x;
    x.rst = r;  x.v = v;  x.src = src;  x.z = z;  x.l = l;  x.bt = bt;  x.jt = jt;
    x.st = st;  x.rdy = rdy;  x.ereq = ereq;  x.eaddr = eaddr;  x.eredir = eredir;
    x.ekill = ekill;  x.etrap = etrap;
    vecs.push_back(x);
  endtask

  // Drive at the falling edge, let combinational outputs settle before sampling
  task automatic applyStimulus(input vec_t x);
    @(negedge clk);
    rst         = x.rst;
    br_valid    = x.v;
    br_src      = x.src;
    br_zero     = x.z;
    br_less     = x.l;
    br_target   = x.bt;
    jalr_target = x.jt;
    stall       = x.st;
    if_ready    = x.rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll(input vec_t x, input int idx);
    checkOutput("if_req",        idx, {31'b0, if_req},        {31'b0, x.ereq});
    checkOutput("if_addr",       idx, if_addr,                x.eaddr);
    checkOutput("redirect",      idx, {31'b0, redirect},      {31'b0, x.eredir});
    checkOutput("fetch_kill",    idx, {31'b0, fetch_kill},    {31'b0, x.ekill});
    checkOutput("misalign_trap", idx, {31'b0, misalign_trap}, {31'b0, x.etrap});
  endtask

  function automatic vec_t mk(input logic r, input logic rdy, input logic v, input logic [2:0] src,
                              input logic [31:0] bt);
    vec_t x;
    x.rst = r;  x.v = v;  x.src = src;  x.z = 1'b0;  x.l = 1'b0;  x.bt = bt;  x.jt = 32'h0;
    x.st = 1'b0;  x.rdy = rdy;  x.ereq = 1'b0;  x.eaddr = 32'h0;  x.eredir = 1'b0;
    x.ekill = 1'b0;  x.etrap = 1'b0;
    return x;
  endfunction

  initial begin
    vec_t x;
    rst = 1'b1;  br_valid = 1'b0;  br_src = SEQ;  br_zero = 1'b0;  br_less = 1'b0;
    br_target = 32'h0;  jalr_target = 32'h0;  stall = 1'b0;  if_ready = 1'b0;
    repeat (2) @(posedge clk);

    //     rst v  src   z  l  bt             jt             st rdy  req addr           rd kl trap
    addVec(1, 1, JAL,  0, 0, 32'h40,        32'h0,         0, 1,   0, 32'h0,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   0, 32'h0,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h0,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h4,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h8,         0, 0, 0);
    addVec(0, 1, BEQ,  1, 0, 32'h40,        32'h0,         0, 1,   0, 32'hC,         1, 0, 0);
    addVec(0, 1, BEQ,  1, 0, 32'h80,        32'h0,         0, 1,   1, 32'h40,        0, 0, 0);
    addVec(0, 1, BNE,  1, 0, 32'h80,        32'h0,         0, 1,   1, 32'h44,        0, 0, 0);
    addVec(0, 1, JAL,  0, 0, 32'h10,        32'h0,         0, 1,   0, 32'h48,        1, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   1, 32'h10,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         1, 0,   1, 32'h10,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   1, 32'h10,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         1, 1,   1, 32'h10,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         1, 1,   0, 32'h14,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h14,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h18,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h1C,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   1, 32'h20,        0, 0, 0);
    addVec(0, 1, JALR, 0, 0, 32'h0,         32'h81,        0, 0,   1, 32'h20,        1, 0, 0);
    addVec(0, 1, JALR, 0, 0, 32'h0,         32'h200,       0, 0,   1, 32'h20,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   1, 32'h20,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h20,        0, 1, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h80,        0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   1, 32'h84,        0, 0, 0);
    addVec(0, 1, BLT,  0, 1, 32'h30,        32'h0,         0, 1,   1, 32'h84,        1, 1, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h30,        0, 0, 0);
    addVec(0, 1, BGE,  0, 0, 32'h60,        32'h0,         0, 1,   0, 32'h34,        1, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h60,        0, 0, 0);
    addVec(0, 1, BGE,  0, 1, 32'h90,        32'h0,         0, 1,   1, 32'h64,        0, 0, 0);
    addVec(0, 1, BLT,  0, 0, 32'h90,        32'h0,         0, 1,   1, 32'h68,        0, 0, 0);
    addVec(0, 1, RSV,  1, 1, 32'h90,        32'h0,         0, 1,   1, 32'h6C,        0, 0, 0);
    addVec(0, 1, SEQ,  1, 1, 32'h90,        32'h0,         0, 1,   1, 32'h70,        0, 0, 0);
    addVec(0, 1, JAL,  0, 0, 32'h102,       32'h0,         0, 1,   0, 32'h74,        1, 0, TRAP_ON);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h100,       0, 0, 0);
    addVec(0, 1, JALR, 0, 0, 32'h0,         32'hFFFF_FFFD, 0, 1,   0, 32'h104,       1, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'hFFFF_FFFC, 0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h0,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   1, 32'h4,         0, 0, 0);
    addVec(1, 1, JAL,  0, 0, 32'h40,        32'h0,         0, 0,   0, 32'h4,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 0,   0, 32'h0,         0, 0, 0);
    addVec(0, 0, SEQ,  0, 0, 32'h0,         32'h0,         0, 1,   1, 32'h0,         0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll(vecs[i], i);
    end

    // Reset while a redirect is parked in DRAIN: the parked target must be forgotten
    x = mk(0, 0, 1'b0, SEQ, 32'h0);
    x.ereq = 1'b1;  x.eaddr = 32'h4;
    applyStimulus(x);  checkAll(x, 100);
    x = mk(0, 0, 1'b1, JAL, 32'h200);
    x.ereq = 1'b1;  x.eaddr = 32'h4;  x.eredir = 1'b1;
    applyStimulus(x);  checkAll(x, 101);
    x = mk(1, 0, 1'b0, SEQ, 32'h0);
    x.eaddr = 32'h4;
    applyStimulus(x);  checkAll(x, 102);
    x = mk(0, 1, 1'b0, SEQ, 32'h0);
    applyStimulus(x);  checkAll(x, 103);
    for (int i = 0; i < 5; i++) begin
      x = mk(0, 1, 1'b0, SEQ, 32'h0);
      x.ereq = 1'b1;  x.eaddr = 32'(i * 4);
      applyStimulus(x);  checkAll(x, 104 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
